insn_encoder_loader: RTL and testbench
======================================

# insn_encoder_loader

Program loader that packs field-level instruction commands into 32-bit processor instruction words and writes them sequentially into instruction memory. It sits between the host/test interface and the imem write port. It holds the processor in reset via `cpu_hold` until a complete program has been written. It is the encoding counterpart of the processor's opcode decode: it produces the same opcode set and field layout that the datapath consumes.

## Interface
- `ADDR_W`, 12, imem word-address width; depth is 2^ADDR_W words.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: re-arm from DONE.
- `cmd_valid` in 1: command valid.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_opcode` in 5: instruction opcode.
- `cmd_rd`, `cmd_rs`, `cmd_rt`, `cmd_shamt`, `cmd_aluop` in 5 each: register and ALU fields.
- `cmd_imm` in 17: I-type immediate.
- `cmd_target` in 27: JI-type target.
- `cmd_last` in 1: final instruction of the program.
- `imem_we` out 1: imem write strobe.
- `imem_addr` out ADDR_W: write address.
- `imem_data` out 32: encoded instruction word.
- `cpu_hold` out 1: processor held in reset.
- `done` out 1: load finished.
- `ill_op` out 1: sticky, illegal opcode seen.
- `overflow` out 1: sticky, imem full before `cmd_last`.

## Operation
- FSM states are LOAD, WRITE and DONE. Reset enters LOAD.
- `cmd_ready` = (state == LOAD), decoded combinationally from state.
- Encoding depends on the opcode:
  - R (00000): {op, rd, rs, rt, shamt, aluop, 2'b00}.
  - I (addi 00101, sw 00111, lw 01000, bne 00010, blt 00110): {op, rd, rs, imm}.
  - JI (j 00001, jal 00011, setx 10101, bex 10110): {op, target}.
  - JII (jr 00100): {op, rd, 22'b0}.
  - Unused fields are ignored.
- LOAD, on accept of a legal opcode: register the encoded word into `imem_data`, register `ptr` into `imem_addr`, then go to WRITE.
- WRITE: `imem_we`=1 for exactly one cycle, and `ptr` increments. The next state is:
  - If `cmd_last` (captured at accept): DONE, with `done`=1 and `cpu_hold`=0.
  - Else if `ptr` was 2^ADDR_W−1: DONE, with `overflow`=1, `done`=1, and `cpu_hold` staying 1. The write still occurs and `ptr` wraps to 0.
  - Else: LOAD.
- LOAD, on accept of an illegal opcode (any opcode not listed above):
  - Nothing is written and `ptr` is unchanged.
  - `ill_op` is set.
  - The FSM stays in LOAD, or goes to DONE if `cmd_last` (with `cpu_hold` cleared).
- DONE: `cmd_ready`=0 and `cmd_valid` is ignored.
  - `start` causes, at the next edge: LOAD, `ptr`=0, `done`=0, `ill_op`=0, `overflow`=0, `cpu_hold`=1.
  - `start` in LOAD or WRITE is ignored.
- Reset values:
  - `cpu_hold`=1.
  - 0 on `imem_we`, `imem_addr`, `imem_data`, `done`, `ill_op`, `overflow`.
  - `ptr`=0, state LOAD, so `cmd_ready`=1.
- Asserting `reset` mid-WRITE aborts the write: `imem_we` drops asynchronously and no partial state is kept.

## Timing
- Accept at edge N; `imem_we`=1 in cycle N..N+1 with stable addr/data; `we` drops at edge N+1.
- Throughput: one instruction per 2 cycles; `cmd_ready` is low during WRITE.
- `done` and the `cpu_hold` change are registered at the edge that ends the final WRITE cycle. There is no combinational path from `cmd_*` to any imem output.
- `imem_addr` and `imem_data` hold their last values outside WRITE.

## Configuration
- `INSN_ENC_ILLEGAL_CHECK_EN` defined: illegal opcodes are dropped and flagged as in Operation.
- Undefined: `ill_op` is tied to 0. Every opcode not in the R/JI/JII lists is encoded as I-type {op, rd, rs, imm} and written normally.

## Test plan
- Reset, then addi rd=1 rs=0 imm=5 with `cmd_last`=0, then R-type rd=3 rs=1 rt=2 shamt=0 aluop=0 with `cmd_last`=1:
  - First write is 0x28400005 @0, second is 0x00C22000 @1.
  - `done`=1 and `cpu_hold`=0 one edge after the second `we`.
- j target=100, then jr rd=31, then setx target=7 (last):
  - Writes are 0x08000064, 0x27C00000, 0xA8000007 @0..2.
  - `cmd_ready` is low in each WRITE cycle.
- Opcode 11111 then a legal lw (last), with macro defined:
  - No write for 11111, `ill_op`=1, and lw lands @0.
  - Without the macro, 11111 is written @0 and lw @1.
- ADDR_W=2, five commands with no `cmd_last`:
  - Four writes @0..3, then `overflow`=1, `done`=1, `cpu_hold`=1.
  - The fifth command is never accepted.
- From DONE, pulse `start`: flags clear, `ptr`=0, `cpu_hold`=1, and the next command writes @0.
- Assert `reset` during a WRITE cycle:
  - `imem_we` drops immediately.
  - After release the FSM is in LOAD with `ptr`=0 and `cmd_ready`=1.

Source files
------------

// File: rtl/insn_encoder_loader.sv
// Program loader: packs field-level commands into 32-bit instruction words and
// writes them into imem, holding the CPU in reset until the program is complete.
// Optional macro INSN_ENC_ILLEGAL_CHECK_EN drops and flags unknown opcodes.
module insn_encoder_loader #(
    parameter int ADDR_W = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [4:0]        cmd_opcode,
    input  logic [4:0]        cmd_rd,
    input  logic [4:0]        cmd_rs,
    input  logic [4:0]        cmd_rt,
    input  logic [4:0]        cmd_shamt,
    input  logic [4:0]        cmd_aluop,
    input  logic [16:0]       cmd_imm,
    input  logic [26:0]       cmd_target,
    input  logic              cmd_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              ill_op,
    output logic              overflow
);

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    typedef enum logic [1:0] {S_LOAD, S_WRITE, S_DONE} state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] ptr;
    logic              last_q;
    logic [31:0]       enc;
    logic              legal;
    logic              accept;
    logic              ptr_max;

    assign cmd_ready = (state == S_LOAD);
    assign imem_we   = (state == S_WRITE);
    assign accept    = cmd_valid & cmd_ready;
    assign ptr_max   = (ptr == {ADDR_W{1'b1}});

    // Anything not R/JI/JII falls through to the I-type layout.
    always_comb begin
        enc = {cmd_opcode, cmd_rd, cmd_rs, cmd_imm};
        case (cmd_opcode)
            OP_R:                         enc = {cmd_opcode, cmd_rd, cmd_rs, cmd_rt,
                                                 cmd_shamt, cmd_aluop, 2'b00};
            OP_J, OP_JAL, OP_SETX, OP_BEX: enc = {cmd_opcode, cmd_target};
            OP_JR:                        enc = {cmd_opcode, cmd_rd, 22'b0};
            default: ;
        endcase
    end

`ifdef INSN_ENC_ILLEGAL_CHECK_EN
    always_comb begin
        legal = 1'b0;
        case (cmd_opcode)
            OP_R, OP_J, OP_BNE, OP_JAL, OP_JR, OP_ADDI, OP_BLT,
            OP_SW, OP_LW, OP_SETX, OP_BEX: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    logic ill_q;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            ill_q <= 1'b0;
        else if (accept && !legal)
            ill_q <= 1'b1;
        else if (state == S_DONE && start)
            ill_q <= 1'b0;
    end
    assign ill_op = ill_q;
`else
    assign legal  = 1'b1;
    assign ill_op = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= S_LOAD;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_LOAD: begin
                if (accept) begin
                    if (legal)
                        state_d = S_WRITE;
                    else if (cmd_last)
                        state_d = S_DONE;
                end
            end
            S_WRITE: begin
                if (last_q || ptr_max)
                    state_d = S_DONE;
                else
                    state_d = S_LOAD;
            end
            S_DONE: begin
                if (start)
                    state_d = S_LOAD;
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr       <= '0;
            last_q    <= 1'b0;
            imem_addr <= '0;
            imem_data <= '0;
            done      <= 1'b0;
            cpu_hold  <= 1'b1;
            overflow  <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (accept && legal) begin
                        imem_data <= enc;
                        imem_addr <= ptr;
                        last_q    <= cmd_last;
                    end else if (accept && cmd_last) begin
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end
                end
                S_WRITE: begin
                    ptr <= ptr + ADDR_W'(1);
                    // A final write at the top address is a clean finish, not overflow.
                    if (last_q) begin
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else if (ptr_max) begin
                        overflow <= 1'b1;
                        done     <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        ptr      <= '0;
                        done     <= 1'b0;
                        overflow <= 1'b0;
                        cpu_hold <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_insn_encoder_loader.sv
// Self-checking bench for insn_encoder_loader: vector table plus imem-write scoreboard,
// with hand sequences for overflow, restart and reset during a write.
module tb_insn_encoder_loader;
    localparam int AW = 2;

`ifdef INSN_ENC_ILLEGAL_CHECK_EN
    localparam logic EXP_ILL = 1'b1;
`else
    localparam logic EXP_ILL = 1'b0;
`endif

    typedef struct {
        logic [4:0]    op, rd, rs, rt, sh, alu;
        logic [16:0]   imm;
        logic [26:0]   tgt;
        logic          last;
        logic          wr;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [4:0]    cmd_opcode = '0, cmd_rd = '0, cmd_rs = '0, cmd_rt = '0;
    logic [4:0]    cmd_shamt = '0, cmd_aluop = '0;
    logic [16:0]   cmd_imm = '0;
    logic [26:0]   cmd_target = '0;
    logic          cmd_last = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic          cpu_hold, done, ill_op, overflow;

    int   checks = 0;
    int   errors = 0;
    wr_t  sb[$];
    vec_t tbl[0:13];

    always #5 clock = ~clock;

    insn_encoder_loader #(.ADDR_W(AW)) dut (
        .clock(clock), .reset(reset), .start(start),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
        .cmd_shamt(cmd_shamt), .cmd_aluop(cmd_aluop), .cmd_imm(cmd_imm),
        .cmd_target(cmd_target), .cmd_last(cmd_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data),
        .cpu_hold(cpu_hold), .done(done), .ill_op(ill_op), .overflow(overflow)
    );

    function automatic vec_t mk(input logic [4:0] op, rd, rs, rt, sh, alu,
                                input logic [16:0] imm, input logic [26:0] tgt,
                                input logic last, wr, input logic [AW-1:0] addr,
                                input logic [31:0] data);
        vec_t v;
        v.op = op; v.rd = rd; v.rs = rs; v.rt = rt; v.sh = sh; v.alu = alu;
        v.imm = imm; v.tgt = tgt; v.last = last; v.wr = wr; v.addr = addr; v.data = data;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: every imem write must match the next queued expectation.
    always @(negedge clock) begin
        wr_t e;
        if (imem_we) begin
            chk("ready_low_in_write", {31'b0, cmd_ready}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write got addr %h data %h expected no write",
                         imem_addr, imem_data);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", {30'b0, imem_addr}, {30'b0, e.addr});
                chk("wr_data", imem_data, e.data);
            end
        end
    end

    task automatic send(input vec_t v);
        int n = 0;
        while (!cmd_ready && n < 10) begin
            @(negedge clock);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got cmd_ready 0 expected 1");
            return;
        end
        cmd_opcode = v.op; cmd_rd = v.rd; cmd_rs = v.rs; cmd_rt = v.rt;
        cmd_shamt = v.sh; cmd_aluop = v.alu; cmd_imm = v.imm; cmd_target = v.tgt;
        cmd_last = v.last;
        cmd_valid = 1'b1;
        if (v.wr) sb.push_back('{v.addr, v.data});
        @(posedge clock);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        chk("start_done", {31'b0, done}, 32'd0);
        chk("start_hold", {31'b0, cpu_hold}, 32'd1);
        chk("start_ovf", {31'b0, overflow}, 32'd0);
        chk("start_ill", {31'b0, ill_op}, 32'd0);
        chk("start_ready", {31'b0, cmd_ready}, 32'd1);
    endtask

    task automatic chk_done(input logic exp_hold, input logic exp_ovf);
        @(posedge clock);
        #1;
        chk("done", {31'b0, done}, 32'd1);
        chk("cpu_hold", {31'b0, cpu_hold}, {31'b0, exp_hold});
        chk("overflow", {31'b0, overflow}, {31'b0, exp_ovf});
        chk("ready_in_done", {31'b0, cmd_ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(5'd5, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'd5, 27'd0, 1'b0, 1'b1, 2'd0, 32'h28400005);
        tbl[1]  = mk(5'd0, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0, 17'h1FFFF, 27'h5555555, 1'b1, 1'b1, 2'd1, 32'h00C22000);
        tbl[2]  = mk(5'd1, 5'd5, 5'd6, 5'd0, 5'd0, 5'd0, 17'd3, 27'd100, 1'b0, 1'b1, 2'd0, 32'h08000064);
        tbl[3]  = mk(5'd4, 5'd31, 5'd7, 5'd1, 5'd1, 5'd1, 17'd3, 27'd9, 1'b0, 1'b1, 2'd1, 32'h27C00000);
        tbl[4]  = mk(5'd21, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd7, 1'b1, 1'b1, 2'd2, 32'hA8000007);
`ifdef INSN_ENC_ILLEGAL_CHECK_EN
        tbl[5]  = mk(5'd31, 5'd2, 5'd3, 5'd0, 5'd0, 5'd0, 17'h1234, 27'd0, 1'b0, 1'b0, 2'd0, 32'h0);
        tbl[6]  = mk(5'd8, 5'd4, 5'd5, 5'd0, 5'd0, 5'd0, 17'h10, 27'd0, 1'b1, 1'b1, 2'd0, 32'h410A0010);
`else
        tbl[5]  = mk(5'd31, 5'd2, 5'd3, 5'd0, 5'd0, 5'd0, 17'h1234, 27'd0, 1'b0, 1'b1, 2'd0, 32'hF8861234);
        tbl[6]  = mk(5'd8, 5'd4, 5'd5, 5'd0, 5'd0, 5'd0, 17'h10, 27'd0, 1'b1, 1'b1, 2'd1, 32'h410A0010);
`endif
        tbl[7]  = mk(5'd5, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'd1, 27'd0, 1'b0, 1'b1, 2'd0, 32'h28400001);
        tbl[8]  = mk(5'd5, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 17'd2, 27'd0, 1'b0, 1'b1, 2'd1, 32'h28800002);
        tbl[9]  = mk(5'd0, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 17'd0, 27'd0, 1'b0, 1'b1, 2'd2, 32'h07FFFFFC);
        tbl[10] = mk(5'd5, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 17'd4, 27'd0, 1'b0, 1'b1, 2'd3, 32'h29000004);
        tbl[11] = mk(5'd7, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 17'hFF, 27'd0, 1'b0, 1'b1, 2'd0, 32'h384400FF);
        tbl[12] = mk(5'd2, 5'd3, 5'd4, 5'd0, 5'd0, 5'd0, 17'd1, 27'd0, 1'b0, 1'b0, 2'd1, 32'h0);
        tbl[13] = mk(5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'h7FFFFFF, 1'b1, 1'b1, 2'd0, 32'h1FFFFFFF);

        #2 reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_hold", {31'b0, cpu_hold}, 32'd1);
        chk("rst_we", {31'b0, imem_we}, 32'd0);
        chk("rst_addr", {30'b0, imem_addr}, 32'd0);
        chk("rst_data", imem_data, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_ill", {31'b0, ill_op}, 32'd0);
        chk("rst_ovf", {31'b0, overflow}, 32'd0);
        chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
        reset = 1'b1;
        @(negedge clock);

        // addi then last R-type; done lands one edge after the final write
        for (int i = 0; i <= 1; i++) send(tbl[i]);
        chk("done_in_write", {31'b0, done}, 32'd0);
        chk_done(1'b0, 1'b0);
        chk("addr_hold", {30'b0, imem_addr}, 32'd1);
        chk("data_hold", imem_data, 32'h00C22000);
        // commands offered in DONE must be ignored
        @(negedge clock);
        cmd_valid = 1'b1;
        repeat (3) @(negedge clock);
        cmd_valid = 1'b0;
        chk("done_ignores_cmd", {31'b0, done}, 32'd1);
        pulse_start();

        // j / jr / setx
        for (int i = 2; i <= 4; i++) send(tbl[i]);
        chk_done(1'b0, 1'b0);
        pulse_start();

        // opcode 11111 then lw (last)
        send(tbl[5]);
        @(negedge clock);
        chk("ill_op_flag", {31'b0, ill_op}, {31'b0, EXP_ILL});
        send(tbl[6]);
        chk_done(1'b0, 1'b0);
        chk("ill_op_sticky", {31'b0, ill_op}, {31'b0, EXP_ILL});
        pulse_start();

        // fill all four words with no last: overflow, CPU stays held
        for (int i = 7; i <= 10; i++) send(tbl[i]);
        chk_done(1'b1, 1'b1);
        @(negedge clock);
        cmd_opcode = 5'd5; cmd_last = 1'b0;
        cmd_valid = 1'b1;
        repeat (4) @(negedge clock);
        cmd_valid = 1'b0;
        chk("fifth_not_accepted", {31'b0, cmd_ready}, 32'd0);
        chk("ovf_sticky", {31'b0, overflow}, 32'd1);
        pulse_start();

        // one full write, then reset in the middle of the next write
        send(tbl[11]);
        send(tbl[12]);
        chk("we_before_abort", {31'b0, imem_we}, 32'd1);
        reset = 1'b0;
        #1;
        chk("we_async_drop", {31'b0, imem_we}, 32'd0);
        chk("abort_ready", {31'b0, cmd_ready}, 32'd1);
        chk("abort_hold", {31'b0, cpu_hold}, 32'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        send(tbl[13]);
        chk_done(1'b0, 1'b0);

        repeat (2) @(negedge clock);
        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
